vga_rx640x480: RTL and testbench

VGA_RX640X480 -- requirements
Module: vga_rx640x480

---
 rtl/vga_rx640x480_if.sv | 26 ++
 rtl/vga_rx640x480.sv | 202 ++++++++++++++++++++
 tb/tb_vga_rx640x480.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_rx640x480_if.sv
// Bundle of video inputs (syncs, colours) and decoded-row outputs for vga_rx640x480.
interface vga_rx640x480_if;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        locked;
  logic        sync_err;
  logic        row_valid;
  logic [7:0]  row_data;
  logic [63:0] row_word;
  logic [9:0]  row_index;
  logic        row_err;
  logic        frame_done;

  modport master (
    output hsync, vsync, red, green, blue,
    input  locked, sync_err, row_valid, row_data, row_word, row_index, row_err, frame_done
  );

  modport slave (
    input  hsync, vsync, red, green, blue,
    output locked, sync_err, row_valid, row_data, row_word, row_index, row_err, frame_done
  );
endinterface

// File: rtl/vga_rx640x480.sv
// Locks onto 640x480 VGA sync timing and decodes one byte per active line from red/blue
// column colours. Define VGA_RX_MAJORITY_EN for 2-of-3 voting around each column centre.
module vga_rx640x480 #(
  parameter int HPIXELS   = 800,
  parameter int VLINES    = 525,
  parameter int HACTIVE   = 640,
  parameter int VACTIVE   = 480,
  parameter int HSYNC_END = 752,
  parameter int VSYNC_END = 492,
  parameter int COLW      = 80
) (
  input  logic           dclk,
  input  logic           clr,
  vga_rx640x480_if.slave vif
);
  localparam int         NCOL       = HACTIVE / COLW;
  localparam logic [9:0] H_LAST     = 10'(HPIXELS - 1);
  localparam logic [9:0] V_LAST     = 10'(VLINES - 1);
  localparam logic [9:0] H_ACT      = 10'(HACTIVE);
  localparam logic [9:0] V_ACT      = 10'(VACTIVE);
  localparam logic [9:0] V_LAST_ROW = 10'(VACTIVE - 1);
  localparam logic [9:0] HS_END     = 10'(HSYNC_END);
  localparam logic [9:0] VS_END     = 10'(VSYNC_END);
  localparam logic [9:0] HS_NEXT    = (HSYNC_END == HPIXELS - 1) ? 10'd0 : 10'(HSYNC_END + 1);

  typedef enum logic [1:0] {IDLE, H_ACQ, V_ACQ, LOCKED} state_t;
  state_t state, next_state;

  logic       hsync_p1, vsync_p1, red_p1, blue_p1;
  logic       hsync_p2, vsync_p2;
  logic [9:0] rx_hc, rx_vc, hc_next, vc_next;
  logic       hs_edge, vs_edge, h_bad, v_bad;
  logic       locked_c, sync_err_c, stay_locked, row_fire, line_ok, active_v;
  logic [1:0] dec_p1;
  logic [7:0] col_bits;
  logic       row_flag;
  logic       row_valid_q, frame_done_q, sync_err_q, row_err_q;
  logic [7:0] row_data_q;
  logic [9:0] row_index_q;
  logic       unused_bits;

  // Only the colour MSBs carry information; green is not used at all.
  assign unused_bits = ^{vif.green, vif.red[2:0], vif.blue[2:0]};

  // Returns {invalid, bit}: red-only is 1, blue-only is 0, anything else is invalid.
  function automatic logic [1:0] decide(input logic r, input logic b);
    logic [1:0] d;
    d = 2'b10;
    if (r && !b) d = 2'b01;
    if (!r && b) d = 2'b00;
    return d;
  endfunction

  function automatic logic at_col(input logic [9:0] hc, input int off);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NCOL; k++)
      if (int'(hc) == COLW * k + COLW / 2 + off) hit = 1'b1;
    return hit;
  endfunction

  // Stage 1: input registers; stage 2: delayed sync copies for edge detection
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      red_p1   <= 1'b0;
      blue_p1  <= 1'b0;
      hsync_p2 <= 1'b1;
      vsync_p2 <= 1'b1;
    end else begin
      hsync_p1 <= vif.hsync;
      vsync_p1 <= vif.vsync;
      red_p1   <= vif.red[3];
      blue_p1  <= vif.blue[3];
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
    end
  end

  assign hs_edge  = hsync_p1 & ~hsync_p2;
  assign vs_edge  = vsync_p1 & ~vsync_p2;
  assign dec_p1   = decide(red_p1, blue_p1);
  assign active_v = (rx_vc < V_ACT);
  assign h_bad    = hs_edge ^ (rx_hc == HS_END);
  assign v_bad    = vs_edge ^ ((rx_vc == VS_END) && (rx_hc == '0));
  assign hc_next  = (rx_hc == H_LAST) ? '0 : rx_hc + 10'd1;
  assign vc_next  = (rx_hc != H_LAST) ? rx_vc : ((rx_vc == V_LAST) ? '0 : rx_vc + 10'd1);

  // rx_hc names the column held in stage 1; a reload makes the edge cycle itself read
  // HSYNC_END (or column 0 for vsync), so the register takes the following value.
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      rx_hc <= '0;
      rx_vc <= '0;
    end else if (vs_edge && !locked_c) begin
      rx_hc <= 10'd1;
      rx_vc <= VS_END;
    end else if (hs_edge && !locked_c) begin
      rx_hc <= HS_NEXT;
    end else begin
      rx_hc <= hc_next;
      rx_vc <= vc_next;
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hs_edge) next_state = H_ACQ;
      H_ACQ:   if (hs_edge) next_state = (rx_hc == HS_END) ? V_ACQ : IDLE;
      V_ACQ:   if (vs_edge) next_state = LOCKED;
      LOCKED:  if (h_bad || v_bad) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    locked_c    = (state == LOCKED);
    sync_err_c  = locked_c && (h_bad || v_bad);
    stay_locked = locked_c && (next_state == LOCKED);
  end

`ifdef VGA_RX_MAJORITY_EN
  logic vote_a, vote_b;

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      col_bits <= '0;
      row_flag <= 1'b0;
      vote_a   <= 1'b0;
      vote_b   <= 1'b0;
    end else if (rx_hc == '0) begin
      col_bits <= '0;
      row_flag <= 1'b0;
    end else if (active_v) begin
      if (at_col(rx_hc, -1)) begin
        vote_a   <= dec_p1[0];
        row_flag <= row_flag | dec_p1[1];
      end else if (at_col(rx_hc, 0)) begin
        vote_b   <= dec_p1[0];
        row_flag <= row_flag | dec_p1[1];
      end else if (at_col(rx_hc, 1)) begin
        col_bits <= {col_bits[6:0], (vote_a & vote_b) | (vote_a & dec_p1[0]) | (vote_b & dec_p1[0])};
        row_flag <= row_flag | dec_p1[1];
      end
    end
  end
`else
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      col_bits <= '0;
      row_flag <= 1'b0;
    end else if (rx_hc == '0) begin
      col_bits <= '0;
      row_flag <= 1'b0;
    end else if (active_v && at_col(rx_hc, 0)) begin
      col_bits <= {col_bits[6:0], dec_p1[0]};
      row_flag <= row_flag | dec_p1[1];
    end
  end
`endif

  // A row is published only if lock held from column 0 through the end of the active area.
  assign row_fire = stay_locked && line_ok && active_v && (rx_hc == H_ACT);

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      line_ok      <= 1'b0;
      sync_err_q   <= 1'b0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      row_data_q   <= '0;
      row_index_q  <= '0;
      row_err_q    <= 1'b0;
    end else begin
      line_ok      <= stay_locked && ((rx_hc == '0) || line_ok);
      sync_err_q   <= sync_err_c;
      row_valid_q  <= row_fire;
      frame_done_q <= row_fire && (rx_vc == V_LAST_ROW);
      if (row_fire) begin
        row_data_q  <= col_bits;
        row_index_q <= rx_vc;
        row_err_q   <= row_flag;
      end
    end
  end

  assign vif.locked     = locked_c;
  assign vif.sync_err   = sync_err_q;
  assign vif.row_valid  = row_valid_q;
  assign vif.frame_done = frame_done_q;
  assign vif.row_data   = row_data_q;
  assign vif.row_word   = {row_data_q, 56'b0};
  assign vif.row_index  = row_index_q;
  assign vif.row_err    = row_err_q;
endmodule

// File: tb/tb_vga_rx640x480.sv
// Bench for vga_rx640x480 on a scaled-down raster: random column data, sync faults,
// forced invalid colours, centre-pixel glitches and a mid-frame clear.
module tb_vga_rx640x480;
  localparam int HP = 80, VL = 16, HA = 64, VA = 12, HSE = 76, VSE = 14, CW = 8;
  localparam int NFR = 10;

  logic dclk = 1'b0;
  logic clr  = 1'b1;
  always #5 dclk = ~dclk;

  vga_rx640x480_if vif();

  vga_rx640x480 #(
    .HPIXELS(HP), .VLINES(VL), .HACTIVE(HA), .VACTIVE(VA),
    .HSYNC_END(HSE), .VSYNC_END(VSE), .COLW(CW)
  ) dut (
    .dclk(dclk),
    .clr (clr),
    .vif (vif)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] red_a   [VL][HP];
  logic [3:0] blue_a  [VL][HP];
  logic [3:0] green_a [VL][HP];
  logic [7:0] data_a  [VL];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Colour rule: red-only -> 1, blue-only -> 0, else invalid. Returns {invalid, bit}.
  function automatic logic [1:0] colour_bit(input logic [3:0] r, input logic [3:0] b);
    if (r[3] && !b[3]) return 2'b01;
    if (!r[3] && b[3]) return 2'b00;
    return 2'b10;
  endfunction

  // Expected {row_err, row_data} for one line, straight from the pixel arrays.
  function automatic logic [8:0] model_row(input int l);
    logic [7:0] d;
    logic       e;
    int         ones;
    logic [1:0] s;
    d = '0;
    e = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ones = 0;
`ifdef VGA_RX_MAJORITY_EN
      for (int o = -1; o <= 1; o++) begin
        s = colour_bit(red_a[l][CW*k + CW/2 + o], blue_a[l][CW*k + CW/2 + o]);
        ones += int'(s[0]);
        e |= s[1];
      end
      d[7-k] = (ones >= 2);
`else
      s = colour_bit(red_a[l][CW*k + CW/2], blue_a[l][CW*k + CW/2]);
      d[7-k] = s[0];
      e |= s[1];
`endif
    end
    return {e, d};
  endfunction

  task automatic build_frame();
    int   off;
    logic bitv;
    for (int l = 0; l < VL; l++)
      for (int c = 0; c < HP; c++) begin
        green_a[l][c] = 4'($urandom_range(0, 15));
        if (l < VA && c < HA) begin
          bitv = data_a[l][7 - c/CW];
          off  = c % CW;
          if ((off < CW/2 - 1 || off > CW/2 + 1) && $urandom_range(0, 7) == 0) begin
            red_a[l][c]  = 4'($urandom_range(0, 15));
            blue_a[l][c] = 4'($urandom_range(0, 15));
          end else if (bitv) begin
            red_a[l][c]  = 4'(8 + $urandom_range(0, 7));
            blue_a[l][c] = 4'($urandom_range(0, 7));
          end else begin
            red_a[l][c]  = 4'($urandom_range(0, 7));
            blue_a[l][c] = 4'(8 + $urandom_range(0, 7));
          end
        end else begin
          red_a[l][c]  = 4'h0;
          blue_a[l][c] = 4'h0;
        end
      end
  endtask

  initial begin
    int         lock_from, cut_f, cut_l;
    int         fault_f, fault_l, clr_f, clr_l, clr_c;
    int         se_cnt;
    logic       line_exp, exp_rv;
    logic [8:0] m;
    logic [7:0] last_data;
    logic [9:0] last_index;

    vif.hsync = 1'b1; vif.vsync = 1'b1;
    vif.red = 4'h0; vif.green = 4'h0; vif.blue = 4'h0;
    lock_from = 1; cut_f = -1; cut_l = -1;
    fault_f = 3; fault_l = 4;
    clr_f = 7; clr_l = 5; clr_c = 20;
    last_data = '0; last_index = '0;

    repeat (3) @(posedge dclk);
    #1;
    check_val("rst_locked",     vif.locked,     0);
    check_val("rst_sync_err",   vif.sync_err,   0);
    check_val("rst_row_valid",  vif.row_valid,  0);
    check_val("rst_row_data",   vif.row_data,   0);
    check_val("rst_row_word",   vif.row_word,   0);
    check_val("rst_row_index",  vif.row_index,  0);
    check_val("rst_row_err",    vif.row_err,    0);
    check_val("rst_frame_done", vif.frame_done, 0);
    @(posedge dclk);
    #1 clr = 1'b0;

    for (int f = 0; f < NFR; f++) begin
      for (int l = 0; l < VL; l++) begin
        if (f < 2)        data_a[l] = 8'hA5;
        else if (f == 7)  data_a[l] = 8'($urandom_range(1, 255));
        else              data_a[l] = 8'($urandom_range(0, 255));
      end
      if (f == 6) data_a[2] = 8'hFF;
      build_frame();
      if (f == 5)
        for (int c = 3*CW; c < 4*CW; c++) begin
          red_a[10][c] = 4'h0;
          blue_a[10][c] = 4'h0;
        end
      if (f == 6) begin
        red_a[2][CW/2]  = 4'($urandom_range(0, 7));
        blue_a[2][CW/2] = 4'(8 + $urandom_range(0, 7));
      end
      if (f == fault_f) begin cut_f = f; cut_l = fault_l;   lock_from = f + 1; end
      if (f == clr_f)   begin cut_f = f; cut_l = clr_l - 1; lock_from = f + 1; end
      se_cnt = 0;

      for (int l = 0; l < VL; l++) begin
        for (int c = 0; c < HP; c++) begin
          @(posedge dclk);
          #1;
          if (f == fault_f && l == fault_l) vif.hsync = !(c >= HSE - 7 && c <= HSE);
          else                              vif.hsync = !(c >= HSE - 8 && c < HSE);
          vif.vsync = !(l >= VSE - 2 && l < VSE);
          vif.red   = red_a[l][c];
          vif.green = green_a[l][c];
          vif.blue  = blue_a[l][c];
          if (f == clr_f && l == clr_l && c == clr_c) begin
            clr = 1'b1;
            #1;
            check_val("clr_locked",    vif.locked,    0);
            check_val("clr_row_data",  vif.row_data,  0);
            check_val("clr_row_word",  vif.row_word,  0);
            check_val("clr_row_index", vif.row_index, 0);
            check_val("clr_row_err",   vif.row_err,   0);
            last_data = '0;
            last_index = '0;
          end else begin
            clr = 1'b0;
          end

          @(negedge dclk);
          line_exp = (l < VA) && (f >= lock_from || f == cut_f) && !(f == cut_f && l > cut_l);
          exp_rv   = line_exp && (c == HA + 2);
          if (vif.sync_err) se_cnt++;
          check_val("row_valid",  vif.row_valid,  exp_rv);
          check_val("frame_done", vif.frame_done, exp_rv && (l == VA - 1));
          if (l < VA && c == HA/2) check_val("locked", vif.locked, line_exp);
          if (c == 0) begin
            check_val("hold_data",  vif.row_data,  last_data);
            check_val("hold_index", vif.row_index, last_index);
          end
          if (exp_rv && vif.row_valid) begin
            m = model_row(l);
            check_val("row_data",  vif.row_data,  m[7:0]);
            check_val("row_word",  vif.row_word,  {m[7:0], 56'b0});
            check_val("row_index", vif.row_index, l);
            check_val("row_err",   vif.row_err,   m[8]);
            if (f == 1) begin
              check_val("a5_data", vif.row_data, 8'hA5);
              check_val("a5_word", vif.row_word, 64'hA500_0000_0000_0000);
            end
            if (f == 5 && l == 10) begin
              check_val("forced_err",  vif.row_err,     1);
              check_val("forced_bit4", vif.row_data[4], 0);
            end
            if (f == 5 && l == 11) check_val("next_err", vif.row_err, 0);
            if (f == 6 && l == 2) begin
`ifdef VGA_RX_MAJORITY_EN
              check_val("glitch_data", vif.row_data, 8'hFF);
`else
              check_val("glitch_data", vif.row_data, 8'h7F);
`endif
              check_val("glitch_err", vif.row_err, 0);
            end
            last_data  = m[7:0];
            last_index = 10'(l);
          end
        end
      end
      check_val("sync_err_cnt", se_cnt, (f == fault_f) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
